elevator_scan_ctrl: RTL and testbench

- Parametrised N-floor elevator controller; successor to the fixed 4-floor, single-target elevator FSM.
- Latches floor-call buttons into a pending vector and serves them in SCAN order: keep direction while calls remain ahead, else reverse.
- Adds a door dwell timer, homing after reset, emergency halt and floor-sensor fault detection.
- Drives the motor code and floor/target values consumed by the existing seven-segment encoders.

---
 rtl/elevator_pkg.sv | 56 +++++
 rtl/elevator_scan_ctrl_floor_onehot_enc.sv | 24 ++
 rtl/elevator_scan_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings, state/direction types and the SCAN nearest-call search for the elevator controller.
// Pure declarations; no timing or flow control of its own.
package elevator_pkg;

  localparam int MAX_FLOORS = 15;
  localparam int MAX_FW     = 4;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  typedef enum logic [2:0] {
    HOMING,
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR,
    HALT
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  typedef logic [MAX_FLOORS-1:0] floor_vec_t;
  typedef logic [MAX_FW-1:0]     floor_num_t;

  // Lowest pending floor strictly above 'from'; 0 when there is none.
  function automatic floor_num_t nearest_above(input floor_vec_t calls, input floor_num_t from);
    floor_num_t r;
    r = '0;
    for (int f = MAX_FLOORS; f >= 1; f--) begin
      if (f > int'(from) && calls[f-1]) r = floor_num_t'(f);
    end
    return r;
  endfunction

  // Highest pending floor strictly below 'from'; 0 when there is none.
  function automatic floor_num_t nearest_below(input floor_vec_t calls, input floor_num_t from);
    floor_num_t r;
    r = '0;
    for (int f = 1; f <= MAX_FLOORS; f++) begin
      if (f < int'(from) && calls[f-1]) r = floor_num_t'(f);
    end
    return r;
  endfunction

  function automatic floor_vec_t floor_bit(input floor_num_t f);
    floor_vec_t v;
    v = '0;
    if (f != '0) v[f - 4'd1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/elevator_scan_ctrl_floor_onehot_enc.sv
// One-hot floor sensor to floor number, with valid (exactly one bit) and multi_hot flags.
// Purely combinational, zero latency, no flow control.
module floor_onehot_enc #(
  parameter int N_FLOORS = 4,
  parameter int FW       = $clog2(N_FLOORS + 1)
) (
  input  logic [N_FLOORS-1:0] sensor,
  output logic [FW-1:0]       floor_num,
  output logic                valid,
  output logic                multi_hot
);

  always_comb begin
    floor_num = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (sensor[i]) floor_num = floor_num | FW'(i + 1);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hot = |(sensor & (sensor - N_FLOORS'(1)));
  assign valid     = (sensor != '0) && !multi_hot;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order N-floor elevator controller: all outputs registered, sensor-to-output latency 2 edges, calls latch 1 edge after press.
// No backpressure: buttons, sensor and estop are level inputs sampled every cycle.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = 4,
  parameter int DOOR_CYCLES = 8,
  parameter int FW          = $clog2(N_FLOORS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] req_btn,
  input  logic [N_FLOORS-1:0] floor_sensor,
  input  logic                estop,
  output logic [1:0]          motor,
  output logic [FW-1:0]       cur_floor,
  output logic [FW-1:0]       target_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                door_open,
  output logic                fault
);

  localparam int             CW         = $clog2(DOOR_CYCLES + 1);
  localparam logic [CW-1:0]  DWELL_LOAD = CW'(DOOR_CYCLES - 1);

  logic [N_FLOORS-1:0] sens_q;
  logic [FW-1:0]       enc_floor;
  logic                enc_vld;
  logic                enc_multi;

  state_t              state_q, state_d;
  dir_t                dir_q, dir_d;
  logic [1:0]          motor_q, motor_d;
  logic [FW-1:0]       cur_q, cur_d;
  logic [FW-1:0]       tgt_q, tgt_d;
  logic [N_FLOORS-1:0] pend_q, pend_d;
  logic                door_q, door_d;
  logic                fault_q, fault_d;
  logic [CW-1:0]       dwell_q, dwell_d;

  logic [N_FLOORS-1:0] set_mask, clr_mask;

  floor_onehot_enc #(
    .N_FLOORS (N_FLOORS),
    .FW       (FW)
  ) u_enc (
    .sensor    (sens_q),
    .floor_num (enc_floor),
    .valid     (enc_vld),
    .multi_hot (enc_multi)
  );

  floor_vec_t          pend_ext;
  floor_num_t          cur_ext, pos_ext;
  floor_num_t          above_idle, below_idle, above_move, below_move;
  logic [N_FLOORS-1:0] cur_mask, pos_mask;
  logic                go_up, go_dn;

  assign pend_ext   = floor_vec_t'(pend_q);
  assign cur_ext    = floor_num_t'(cur_q);
  // While travelling, the freshest known position is the sensor when valid, else the last floor passed.
  assign pos_ext    = enc_vld ? floor_num_t'(enc_floor) : cur_ext;
  assign cur_mask   = N_FLOORS'(floor_bit(cur_ext));
  assign pos_mask   = N_FLOORS'(floor_bit(pos_ext));
  assign above_idle = nearest_above(pend_ext, cur_ext);
  assign below_idle = nearest_below(pend_ext, cur_ext);
  assign above_move = nearest_above(pend_ext, pos_ext);
  assign below_move = nearest_below(pend_ext, pos_ext);
  assign go_up      = (above_idle != '0) && ((dir_q == DIR_UP) || (below_idle == '0));
  assign go_dn      = (below_idle != '0) && !go_up;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    motor_d  = motor_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    door_d   = door_q;
    fault_d  = fault_q;
    dwell_d  = dwell_q;
    clr_mask = '0;
    set_mask = req_btn;
    // Presses for the floor whose door is open are absorbed by the dwell restart instead.
    if (state_q == DOOR) set_mask = req_btn & ~cur_mask;

    if (fault_q || enc_multi) begin
      fault_d = 1'b1;
      state_d = HALT;
      motor_d = MOTOR_STOP;
      tgt_d   = '0;
    end else if (estop) begin
      state_d = HALT;
      motor_d = MOTOR_STOP;
      tgt_d   = '0;
    end else begin
      case (state_q)
        HOMING: begin
          tgt_d   = '0;
          motor_d = MOTOR_DOWN;
          if (enc_vld) begin
            cur_d   = enc_floor;
            motor_d = MOTOR_STOP;
            state_d = IDLE;
          end
        end
        IDLE: begin
          motor_d = MOTOR_STOP;
          tgt_d   = '0;
          if ((pend_q & cur_mask) != '0) begin
            state_d  = DOOR;
            door_d   = 1'b1;
            dwell_d  = DWELL_LOAD;
            clr_mask = cur_mask;
            tgt_d    = cur_q;
          end else if (go_up) begin
            state_d = MOVE_UP;
            motor_d = MOTOR_UP;
            dir_d   = DIR_UP;
            tgt_d   = FW'(above_idle);
          end else if (go_dn) begin
            state_d = MOVE_DOWN;
            motor_d = MOTOR_DOWN;
            dir_d   = DIR_DOWN;
            tgt_d   = FW'(below_idle);
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          motor_d = (state_q == MOVE_UP) ? MOTOR_UP : MOTOR_DOWN;
          if (enc_vld) cur_d = enc_floor;
          if (enc_vld && (enc_floor == tgt_q)) begin
            motor_d  = MOTOR_STOP;
            state_d  = DOOR;
            door_d   = 1'b1;
            dwell_d  = DWELL_LOAD;
            clr_mask = pos_mask;
          end else if (state_q == MOVE_UP && above_move != '0 && FW'(above_move) < tgt_q) begin
            tgt_d = FW'(above_move);
          end else if (state_q == MOVE_DOWN && below_move != '0 && FW'(below_move) > tgt_q) begin
            tgt_d = FW'(below_move);
          end
        end
        DOOR: begin
          motor_d = MOTOR_STOP;
          if ((req_btn & cur_mask) != '0) begin
            dwell_d = DWELL_LOAD;
          end else if (dwell_q == '0) begin
            door_d  = 1'b0;
            tgt_d   = '0;
            state_d = IDLE;
          end else begin
            dwell_d = dwell_q - CW'(1);
          end
        end
        HALT: begin
          motor_d = MOTOR_STOP;
          tgt_d   = '0;
          door_d  = 1'b0;
          if (enc_vld) begin
            cur_d   = enc_floor;
            state_d = IDLE;
          end else begin
            state_d = HOMING;
          end
        end
        default: state_d = HOMING;
      endcase
    end

    pend_d = (pend_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sens_q  <= '0;
      state_q <= HOMING;
      dir_q   <= DIR_UP;
      motor_q <= MOTOR_STOP;
      cur_q   <= '0;
      tgt_q   <= '0;
      pend_q  <= '0;
      door_q  <= 1'b0;
      fault_q <= 1'b0;
      dwell_q <= '0;
    end else begin
      sens_q  <= floor_sensor;
      state_q <= state_d;
      dir_q   <= dir_d;
      motor_q <= motor_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      door_q  <= door_d;
      fault_q <= fault_d;
      dwell_q <= dwell_d;
    end
  end

  assign motor        = motor_q;
  assign cur_floor    = cur_q;
  assign target_floor = tgt_q;
  assign pending      = pend_q;
  assign door_open    = door_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl (4 floors, 8-cycle door): homing, SCAN, reversal, door dwell, estop, fault, async reset.
module tb_elevator_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_btn;
  logic [3:0] floor_sensor;
  logic       estop;
  logic [1:0] motor;
  logic [2:0] cur_floor;
  logic [2:0] target_floor;
  logic [3:0] pending;
  logic       door_open;
  logic       fault;

  int n_chk  = 0;
  int n_pass = 0;

  elevator_scan_ctrl #(
    .N_FLOORS    (4),
    .DOOR_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_btn      (req_btn),
    .floor_sensor (floor_sensor),
    .estop        (estop),
    .motor        (motor),
    .cur_floor    (cur_floor),
    .target_floor (target_floor),
    .pending      (pending),
    .door_open    (door_open),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then return at the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_btn = '0; floor_sensor = '0; estop = 1'b0;
    cyc(2);
    n_chk++; if (motor !== 2'b00) $display("FAIL rst_motor got=%b exp=00", motor); else n_pass++;
    n_chk++; if (cur_floor !== 3'd0) $display("FAIL rst_cur got=%0d exp=0", cur_floor); else n_pass++;
    n_chk++; if (target_floor !== 3'd0) $display("FAIL rst_target got=%0d exp=0", target_floor); else n_pass++;
    n_chk++; if (pending !== 4'b0000) $display("FAIL rst_pending got=%b exp=0000", pending); else n_pass++;
    n_chk++; if (door_open !== 1'b0) $display("FAIL rst_door got=%b exp=0", door_open); else n_pass++;
    n_chk++; if (fault !== 1'b0) $display("FAIL rst_fault got=%b exp=0", fault); else n_pass++;
  endtask

  task automatic test_homing;
    rst_n = 1'b1;
    cyc(1);
    n_chk++; if (motor !== 2'b10) $display("FAIL home_motor_first got=%b exp=10", motor); else n_pass++;
    cyc(4);
    n_chk++; if (motor !== 2'b10) $display("FAIL home_motor_hold got=%b exp=10", motor); else n_pass++;
    floor_sensor = 4'b0001;
    cyc(1);
    n_chk++; if (motor !== 2'b10) $display("FAIL home_sensor_latency got=%b exp=10", motor); else n_pass++;
    cyc(1);
    n_chk++; if (motor !== 2'b00) $display("FAIL home_stop got=%b exp=00", motor); else n_pass++;
    n_chk++; if (cur_floor !== 3'd1) $display("FAIL home_cur got=%0d exp=1", cur_floor); else n_pass++;
    cyc(1);
    n_chk++; if (motor !== 2'b00 || target_floor !== 3'd0) $display("FAIL home_idle motor=%b tgt=%0d exp=00/0", motor, target_floor); else n_pass++;
  endtask

  task automatic test_scan_order;
    req_btn = 4'b0100;
    cyc(1);
    n_chk++; if (pending !== 4'b0100) $display("FAIL scan_latch3 got=%b exp=0100", pending); else n_pass++;
    req_btn = '0;
    cyc(1);
    n_chk++; if (motor !== 2'b01 || target_floor !== 3'd3) $display("FAIL scan_go3 motor=%b tgt=%0d exp=01/3", motor, target_floor); else n_pass++;
    floor_sensor = 4'b0000; req_btn = 4'b0010;
    cyc(1);
    n_chk++; if (pending !== 4'b0110) $display("FAIL scan_latch2 got=%b exp=0110", pending); else n_pass++;
    req_btn = '0;
    cyc(1);
    n_chk++; if (target_floor !== 3'd2 || motor !== 2'b01) $display("FAIL scan_retarget tgt=%0d motor=%b exp=2/01", target_floor, motor); else n_pass++;
    floor_sensor = 4'b0010;
    cyc(1);
    n_chk++; if (motor !== 2'b01) $display("FAIL scan_pre_arrive got=%b exp=01", motor); else n_pass++;
    cyc(1);
    n_chk++; if (motor !== 2'b00 || door_open !== 1'b1) $display("FAIL scan_stop2 motor=%b door=%b exp=00/1", motor, door_open); else n_pass++;
    n_chk++; if (cur_floor !== 3'd2 || pending !== 4'b0100) $display("FAIL scan_at2 cur=%0d pend=%b exp=2/0100", cur_floor, pending); else n_pass++;
    cyc(7);
    n_chk++; if (door_open !== 1'b1) $display("FAIL scan_dwell_last got=%b exp=1", door_open); else n_pass++;
    cyc(1);
    n_chk++; if (door_open !== 1'b0 || motor !== 2'b00) $display("FAIL scan_door_close door=%b motor=%b exp=0/00", door_open, motor); else n_pass++;
    cyc(1);
    n_chk++; if (motor !== 2'b01 || target_floor !== 3'd3) $display("FAIL scan_go3_again motor=%b tgt=%0d exp=01/3", motor, target_floor); else n_pass++;
    floor_sensor = 4'b0100;
    cyc(2);
    n_chk++; if (pending !== 4'b0000 || cur_floor !== 3'd3 || door_open !== 1'b1) $display("FAIL scan_at3 pend=%b cur=%0d door=%b exp=0000/3/1", pending, cur_floor, door_open); else n_pass++;
    cyc(8);
  endtask

  task automatic test_reversal;
    req_btn = 4'b1000;
    cyc(1);
    req_btn = '0;
    cyc(1);
    n_chk++; if (motor !== 2'b01 || target_floor !== 3'd4) $display("FAIL rev_go4 motor=%b tgt=%0d exp=01/4", motor, target_floor); else n_pass++;
    floor_sensor = 4'b0000; req_btn = 4'b0001;
    cyc(1);
    n_chk++; if (pending !== 4'b1001 || target_floor !== 3'd4) $display("FAIL rev_latch1 pend=%b tgt=%0d exp=1001/4", pending, target_floor); else n_pass++;
    req_btn = '0; floor_sensor = 4'b1000;
    cyc(2);
    n_chk++; if (motor !== 2'b00 || door_open !== 1'b1 || cur_floor !== 3'd4 || pending !== 4'b0001) $display("FAIL rev_at4 motor=%b door=%b cur=%0d pend=%b exp=00/1/4/0001", motor, door_open, cur_floor, pending); else n_pass++;
    cyc(8);
    n_chk++; if (motor !== 2'b00 || door_open !== 1'b0) $display("FAIL rev_gap motor=%b door=%b exp=00/0", motor, door_open); else n_pass++;
    cyc(1);
    n_chk++; if (motor !== 2'b10 || target_floor !== 3'd1) $display("FAIL rev_go1 motor=%b tgt=%0d exp=10/1", motor, target_floor); else n_pass++;
    floor_sensor = 4'b0001;
    cyc(2);
    n_chk++; if (motor !== 2'b00 || cur_floor !== 3'd1 || pending !== 4'b0000) $display("FAIL rev_at1 motor=%b cur=%0d pend=%b exp=00/1/0000", motor, cur_floor, pending); else n_pass++;
    cyc(9);
    n_chk++; if (target_floor !== 3'd0 || motor !== 2'b00 || door_open !== 1'b0) $display("FAIL rev_idle tgt=%0d motor=%b door=%b exp=0/00/0", target_floor, motor, door_open); else n_pass++;
  endtask

  task automatic test_same_floor;
    // Move up to floor 2 and let the door cycle finish.
    req_btn = 4'b0010;
    cyc(1);
    req_btn = '0;
    cyc(1);
    floor_sensor = 4'b0010;
    cyc(2);
    n_chk++; if (cur_floor !== 3'd2 || door_open !== 1'b1) $display("FAIL same_reach2 cur=%0d door=%b exp=2/1", cur_floor, door_open); else n_pass++;
    cyc(9);
    req_btn = 4'b0010;
    cyc(1);
    n_chk++; if (pending !== 4'b0010 || motor !== 2'b00) $display("FAIL same_latch pend=%b motor=%b exp=0010/00", pending, motor); else n_pass++;
    req_btn = '0;
    cyc(1);
    n_chk++; if (door_open !== 1'b1 || pending !== 4'b0000 || motor !== 2'b00) $display("FAIL same_door door=%b pend=%b motor=%b exp=1/0000/00", door_open, pending, motor); else n_pass++;
    cyc(3);
    req_btn = 4'b0010;
    cyc(1);
    n_chk++; if (pending !== 4'b0000 || door_open !== 1'b1) $display("FAIL same_repress pend=%b door=%b exp=0000/1", pending, door_open); else n_pass++;
    req_btn = '0;
    cyc(7);
    n_chk++; if (door_open !== 1'b1) $display("FAIL same_restart got=%b exp=1", door_open); else n_pass++;
    cyc(1);
    n_chk++; if (door_open !== 1'b0 || motor !== 2'b00) $display("FAIL same_close door=%b motor=%b exp=0/00", door_open, motor); else n_pass++;
  endtask

  task automatic test_estop;
    req_btn = 4'b1000;
    cyc(1);
    req_btn = '0;
    cyc(1);
    n_chk++; if (motor !== 2'b01) $display("FAIL estop_depart got=%b exp=01", motor); else n_pass++;
    floor_sensor = 4'b0000;
    cyc(2);
    estop = 1'b1;
    cyc(1);
    n_chk++; if (motor !== 2'b00 || target_floor !== 3'd0) $display("FAIL estop_halt motor=%b tgt=%0d exp=00/0", motor, target_floor); else n_pass++;
    req_btn = 4'b0100;
    cyc(1);
    n_chk++; if (pending !== 4'b1100) $display("FAIL estop_latch got=%b exp=1100", pending); else n_pass++;
    req_btn = '0; estop = 1'b0;
    cyc(1);
    n_chk++; if (motor !== 2'b00) $display("FAIL estop_release got=%b exp=00", motor); else n_pass++;
    cyc(1);
    n_chk++; if (motor !== 2'b10 || target_floor !== 3'd0) $display("FAIL estop_homing motor=%b tgt=%0d exp=10/0", motor, target_floor); else n_pass++;
    floor_sensor = 4'b0010;
    cyc(2);
    n_chk++; if (motor !== 2'b00 || cur_floor !== 3'd2) $display("FAIL estop_homed motor=%b cur=%0d exp=00/2", motor, cur_floor); else n_pass++;
    cyc(1);
    n_chk++; if (motor !== 2'b01 || target_floor !== 3'd3) $display("FAIL estop_serve motor=%b tgt=%0d exp=01/3", motor, target_floor); else n_pass++;
    floor_sensor = 4'b0100;
    cyc(2);
    n_chk++; if (pending !== 4'b1000 || door_open !== 1'b1) $display("FAIL estop_at3 pend=%b door=%b exp=1000/1", pending, door_open); else n_pass++;
    cyc(8);
  endtask

  task automatic test_fault;
    floor_sensor = 4'b0110;
    cyc(2);
    n_chk++; if (fault !== 1'b1 || motor !== 2'b00 || target_floor !== 3'd0) $display("FAIL fault_set fault=%b motor=%b tgt=%0d exp=1/00/0", fault, motor, target_floor); else n_pass++;
    floor_sensor = 4'b0100; req_btn = 4'b0001;
    cyc(1);
    req_btn = '0;
    cyc(4);
    n_chk++; if (fault !== 1'b1 || motor !== 2'b00 || pending !== 4'b1001) $display("FAIL fault_sticky fault=%b motor=%b pend=%b exp=1/00/1001", fault, motor, pending); else n_pass++;
  endtask

  task automatic test_async_reset;
    rst_n = 1'b0; floor_sensor = 4'b0100;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    n_chk++; if (fault !== 1'b0 || cur_floor !== 3'd3 || motor !== 2'b00) $display("FAIL arst_rehome fault=%b cur=%0d motor=%b exp=0/3/00", fault, cur_floor, motor); else n_pass++;
    req_btn = 4'b0001;
    cyc(1);
    req_btn = '0;
    cyc(1);
    n_chk++; if (motor !== 2'b10 || target_floor !== 3'd1) $display("FAIL arst_move motor=%b tgt=%0d exp=10/1", motor, target_floor); else n_pass++;
    floor_sensor = 4'b0000;
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (motor !== 2'b00 || cur_floor !== 3'd0 || target_floor !== 3'd0) $display("FAIL arst_now motor=%b cur=%0d tgt=%0d exp=00/0/0", motor, cur_floor, target_floor); else n_pass++;
    n_chk++; if (pending !== 4'b0000 || door_open !== 1'b0 || fault !== 1'b0) $display("FAIL arst_now2 pend=%b door=%b fault=%b exp=0000/0/0", pending, door_open, fault); else n_pass++;
    cyc(1);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_homing();
    test_scan_order();
    test_reversal();
    test_same_floor();
    test_estop();
    test_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog sim_time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
